// File: rtl/pattern_seq_4in.sv
// pattern_seq_4in: drives the four gate inputs ina..ind with a deterministic
// pattern sequence (binary, Gray, walking-one or Johnson). Each pattern is held
// for DIV clocks; valid marks the first cycle of each pattern and done pulses
// once after the last hold expires.
// Optional feature: define PATTERN_SEQ_PAUSE_EN to add a pause input that
// freezes the sequence while in RUN.

module pattern_seq_4in #(
  parameter int unsigned DIV = 20,
  parameter int unsigned CW  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
`ifdef PATTERN_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       ina,
  output logic       inb,
  output logic       inc,
  output logic       ind,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [CW-1:0] PrescLast = CW'(DIV - 1);

  state_e          state_q;
  logic [CW-1:0]   presc_q;
  logic [3:0]      idx_q;
  logic [1:0]      mode_q;
  logic            pause_w;

`ifdef PATTERN_SEQ_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Pattern for a given sequence and index, as {ind,inc,inb,ina}.
  function automatic logic [3:0] pat_of(input logic [1:0] m, input logic [3:0] i);
    logic [3:0] p;
    p = 4'b0000;
    unique case (m)
      2'b00: p = i;
      2'b01: p = i ^ (i >> 1);
      2'b10: p = 4'b0001 << i[1:0];
      // Johnson: fill ones from ina upward, then clear from ina upward.
      2'b11: p = i[2] ? (4'b1111 << i[1:0]) : ((4'b0001 << i[1:0]) - 4'd1);
      default: p = 4'b0000;
    endcase
    return p;
  endfunction

  // Index of the final pattern in each sequence.
  function automatic logic [3:0] last_of(input logic [1:0] m);
    logic [3:0] l;
    l = 4'd15;
    unique case (m)
      2'b00, 2'b01: l = 4'd15;
      2'b10:        l = 4'd3;
      2'b11:        l = 4'd7;
      default:      l = 4'd15;
    endcase
    return l;
  endfunction

  // Sequencer FSM with registered pattern and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q               <= StIdle;
      presc_q               <= '0;
      idx_q                 <= 4'd0;
      mode_q                <= 2'b00;
      {ind, inc, inb, ina}  <= 4'b0000;
      valid                 <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
    end else begin
      valid <= 1'b0;
      done  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q              <= StRun;
            mode_q               <= mode;
            presc_q              <= '0;
            idx_q                <= 4'd0;
            {ind, inc, inb, ina} <= pat_of(mode, 4'd0);
            valid                <= 1'b1;
            busy                 <= 1'b1;
          end
        end
        StRun: begin
          // While paused everything holds and valid stays low.
          if (!pause_w) begin
            if (presc_q == PrescLast) begin
              presc_q <= '0;
              if (idx_q == last_of(mode_q)) begin
                state_q              <= StDone;
                idx_q                <= 4'd0;
                {ind, inc, inb, ina} <= 4'b0000;
                busy                 <= 1'b0;
                done                 <= 1'b1;
              end else begin
                idx_q                <= idx_q + 4'd1;
                {ind, inc, inb, ina} <= pat_of(mode_q, idx_q + 4'd1);
                valid                <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/pattern_seq_4in.md
Name: pattern_seq_4in

Overview:
Upstream stimulus stage for the 4-input OR/gate lab blocks. It drives the four gate inputs ina..ind with a selectable deterministic pattern sequence. Each pattern is held for a programmable number of clocks, and the block signals per-pattern and end-of-run events. Its outputs connect directly to the ina/inb/inc/ind inputs of the gate under test.

Parameters:
DIV, 20, clocks each pattern is held; legal range 1..65535
CW, 16, prescaler counter width; must satisfy 2^CW > DIV

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  begin a run; honoured only in IDLE
mode  input  2  sequence select, latched at start: 00 binary, 01 Gray, 10 walking-one, 11 Johnson
ina  output  1  pattern bit 0
inb  output  1  pattern bit 1
inc  output  1  pattern bit 2
ind  output  1  pattern bit 3
valid  output  1  1-cycle pulse in the first cycle of each new pattern
busy  output  1  high while in RUN
done  output  1  1-cycle pulse after the last pattern's hold expires

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset values: ina..ind=0, valid=0, busy=0, done=0, state=IDLE, prescaler=0, index=0, latched mode=00.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on start=1. Latch mode in the same edge. In the next cycle, output pattern index 0 with valid=1 and busy=1.
- RUN: the prescaler counts 0..DIV-1. At DIV-1, the prescaler wraps to 0 and the index increments. The new pattern appears in the next cycle with valid=1.
- RUN -> DONE: when the prescaler reaches DIV-1 on the last index. DONE lasts exactly one cycle: done=1, busy=0, ina..ind=0. Then DONE -> IDLE.
- Pattern sequences, written as {ind,inc,inb,ina} per index:
  - binary (00): length 16; pattern = index (0000..1111).
  - Gray (01): length 16; pattern = index ^ (index>>1).
  - walking-one (10): length 4; 0001, 0010, 0100, 1000.
  - Johnson (11): length 8; 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. Bits toggle in the order ina, inb, inc, ind, repeating.
- Outputs ina..ind are registered. They are stable for exactly DIV cycles per pattern.
- A full run lasts length*DIV cycles in RUN, plus one DONE cycle.
- start while RUN or DONE: ignored, not queued. start=1 held continuously in IDLE starts back-to-back runs. From the DONE cycle, the IDLE cycle follows, then a new run.
- mode changes during RUN: ignored until the next start.
- DIV=1: a new pattern every cycle and valid is high every RUN cycle. The pattern-0 valid is the cycle after start.
- rst_n=0 mid-run: on the next edge all outputs are 0 and state=IDLE. No done pulse is produced.
- Index width is 4 bits. Index never exceeds length-1 for the latched mode.

Optional Feature:
Macro PATTERN_SEQ_PAUSE_EN.
- Defined: adds port pause (input, 1). While pause=1 in RUN:
  - the prescaler and index hold;
  - ina..ind hold;
  - valid=0 and busy stays 1.
  On resume, the count continues from the held value. pause is ignored in IDLE/DONE, and reset overrides pause.
- Undefined: no pause port; behaviour is exactly as above.

Test Plan:
- Reset, then start=1 for 1 cycle with mode=00, DIV=20 -> valid pulses every 20 cycles. Patterns 0000..1111 in order, each held 20 cycles. done pulses 320 cycles after the first valid, then outputs return to 0000.
- mode=01, DIV=2 -> 16 patterns follow the Gray sequence, exactly one bit changing per step. The sequence ends at 1000 before done.
- mode=11, DIV=20 -> 8 Johnson patterns, 0000 then 0001 … 1000, each held 20 cycles. Toggle order is ina, inb, inc, ind; done follows at 160 cycles.
- mode=10, DIV=1, start held high -> patterns 0001, 0010, 0100, 1000 on consecutive cycles. Then a done cycle, an IDLE cycle, and the run restarts at 0001.
- Run mode=00 and assert rst_n=0 at pattern 0101 -> next edge: outputs 0000, busy=0, no done pulse. A subsequent start restarts at 0000.
- Toggle mode and start during RUN -> no effect on the sequence or timing. With PATTERN_SEQ_PAUSE_EN, pause for 7 cycles mid-pattern -> that pattern is held DIV+7 cycles and the total run grows by 7.
